// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle control unit.
//   state_t     - FSM state encodings (also exported on the state port)
//   OP_*        - instruction opcodes as seen on the IR output
//   PC_*        - pc_src mux selects
//   op_class_t  - one-hot-ish class flags produced by op_decode
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALTED = 3'd6,
      S_BAD    = 3'd7
   } state_t;

   localparam logic [3:0] OP_ALU   = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_BEQ   = 4'h4;
   localparam logic [3:0] OP_JMP   = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [1:0] PC_INC = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef struct packed {
      logic is_alu;
      logic is_imm;
      logic is_load;
      logic is_store;
      logic is_beq;
      logic is_jmp;
      logic is_halt;
      logic is_illegal;
   } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: datapath-facing bundle of the control unit.
//   master: drives start/opcode/zero/mem_ready, observes control + status
//   slave : the control unit itself
interface multicycle_ctrl_if;
   logic        start;
   logic [3:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_en;
   logic [1:0]  pc_src;
   logic        ir_en;
   logic        mem_rd;
   logic        mem_wr;
   logic        alu_src;
   logic        rf_we;
   logic        rf_wsel;
   logic [2:0]  state;
   logic        halted;
   logic [15:0] retired;

   modport master (
      output start, opcode, zero, mem_ready,
      input  pc_en, pc_src, ir_en, mem_rd, mem_wr, alu_src, rf_we, rf_wsel,
             state, halted, retired
   );

   modport slave (
      input  start, opcode, zero, mem_ready,
      output pc_en, pc_src, ir_en, mem_rd, mem_wr, alu_src, rf_we, rf_wsel,
             state, halted, retired
   );
endinterface

// File: rtl/multicycle_ctrl_op_decode.sv
// op_decode: maps a 4-bit opcode to instruction class flags.
//   op  in  4  opcode
//   cls out    class flags; exactly one flag is set for any op
module op_decode
   import ctrl_pkg::*;
(
   input  logic [3:0] op,
   output op_class_t  cls
);
   always_comb begin
      cls = '0;
      case (op)
         OP_ALU:   cls.is_alu     = 1'b1;
         OP_ADDI:  cls.is_imm     = 1'b1;
         OP_LOAD:  cls.is_load    = 1'b1;
         OP_STORE: cls.is_store   = 1'b1;
         OP_BEQ:   cls.is_beq     = 1'b1;
         OP_JMP:   cls.is_jmp     = 1'b1;
         OP_HALT:  cls.is_halt    = 1'b1;
         default:  cls.is_illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM control unit for a multicycle core.
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave: start/opcode/zero/mem_ready in; pc/ir/mem/alu/rf controls,
//        state, halted and retired-instruction count out
// Control outputs are combinational from state, op, zero and mem_ready;
// state, op, halted and retired are registers.
module multicycle_ctrl
   import ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   multicycle_ctrl_if.slave bus
);
   state_t    st;
   logic [3:0] op;
   logic [3:0] dec_op;
   op_class_t cls;
   logic      retire;

   // op is only written at the end of DECODE, so DECODE must classify the
   // live IR opcode; every later state uses the captured copy.
   assign dec_op = (st == S_DECODE) ? bus.opcode : op;

   op_decode u_dec (.op(dec_op), .cls(cls));

   assign bus.state = st;

   // Instruction completion points.
   always_comb begin
      retire = 1'b0;
      case (st)
         S_DECODE: retire = cls.is_jmp | cls.is_illegal | cls.is_halt;
         S_EXEC:   retire = cls.is_beq;
         S_MEM:    retire = cls.is_store & bus.mem_ready;
         S_WB:     retire = 1'b1;
         default:  retire = 1'b0;
      endcase
   end

   always_comb begin
      bus.pc_en   = 1'b0;
      bus.pc_src  = PC_INC;
      bus.ir_en   = 1'b0;
      bus.mem_rd  = 1'b0;
      bus.mem_wr  = 1'b0;
      bus.alu_src = 1'b0;
      bus.rf_we   = 1'b0;
      bus.rf_wsel = 1'b0;
      case (st)
         S_FETCH: begin
            bus.mem_rd = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_en = 1'b1;
               bus.pc_en = 1'b1;
            end
         end
         S_DECODE: if (cls.is_jmp) begin
            bus.pc_en  = 1'b1;
            bus.pc_src = PC_JMP;
         end
         S_EXEC: begin
            bus.alu_src = cls.is_imm | cls.is_load | cls.is_store;
            if (cls.is_beq && bus.zero) begin
               bus.pc_en  = 1'b1;
               bus.pc_src = PC_BR;
            end
         end
         S_MEM: begin
            // load/store are exclusive classes, so rd and wr never overlap
            bus.mem_rd = cls.is_load;
            bus.mem_wr = cls.is_store;
         end
         S_WB: begin
            bus.rf_we   = 1'b1;
            bus.rf_wsel = cls.is_load;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= S_IDLE;
         op          <= '0;
         bus.halted  <= 1'b0;
         bus.retired <= '0;
      end else begin
         if (retire) bus.retired <= bus.retired + 16'd1;
         case (st)
            S_IDLE:   if (bus.start) st <= S_FETCH;
            S_FETCH:  if (bus.mem_ready) st <= S_DECODE;
            S_DECODE: begin
               op <= bus.opcode;
               if (cls.is_halt) begin
                  st         <= S_HALTED;
                  bus.halted <= 1'b1;
               end else if (cls.is_jmp || cls.is_illegal) st <= S_FETCH;
               else st <= S_EXEC;
            end
            S_EXEC: begin
               if (cls.is_load || cls.is_store)  st <= S_MEM;
               else if (cls.is_alu || cls.is_imm) st <= S_WB;
               else st <= S_FETCH;
            end
            S_MEM:    if (bus.mem_ready) st <= cls.is_load ? S_WB : S_FETCH;
            S_WB:     st <= S_FETCH;
            S_HALTED: st <= S_HALTED;
            default:  st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed + randomized check of multicycle_ctrl.
// The reference builds each instruction's expected cycle script from the
// per-class latency/output rules and a retired-count scoreboard.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_ctrl_if ifc ();
   multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));

   int nvec = 0;
   int nerr = 0;
   logic [15:0] m_ret;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {pc_en, pc_src, ir_en, mem_rd, mem_wr, alu_src, rf_we, rf_wsel}
   function automatic logic [8:0] cv(input logic pe, input logic [1:0] src, input logic ir,
                                     input logic rd, input logic wr, input logic alu,
                                     input logic we, input logic ws);
      return {pe, src, ir, rd, wr, alu, we, ws};
   endfunction

   function automatic logic [8:0] ctl_now();
      return {ifc.pc_en, ifc.pc_src, ifc.ir_en, ifc.mem_rd, ifc.mem_wr,
              ifc.alu_src, ifc.rf_we, ifc.rf_wsel};
   endfunction

   // one clock: drive mem_ready at negedge, then check the settled cycle
   task automatic cyc(input logic mr, input int st, input logic [8:0] c, input logic hlt);
      @(negedge clk);
      ifc.mem_ready = mr;
      #1;
      chk("state", 32'(ifc.state), st);
      chk("ctl", 32'(ctl_now()), 32'(c));
      chk("halted", 32'(ifc.halted), 32'(hlt));
      chk("rd_wr_excl", 32'(ifc.mem_rd & ifc.mem_wr), 0);
   endtask

   task automatic do_start();
      @(negedge clk);
      ifc.start = 1'b1;
      #1 chk("idle", 32'(ifc.state), 0);
      @(posedge clk);
      #1 chk("start_fetch", 32'(ifc.state), 1);
      ifc.start = 1'b0;
   endtask

   // Expected behaviour of one instruction from FETCH onward, with wf fetch
   // stalls and wm memory stalls.
   task automatic run_instr(input logic [3:0] op, input logic z, input int wf, input int wm);
      logic ld, sto, beq, jmp, hlt, ill;
      ld  = (op == 4'h2);
      sto = (op == 4'h3);
      beq = (op == 4'h4);
      jmp = (op == 4'h5);
      hlt = (op == 4'hF);
      ill = !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF});
      ifc.opcode = op;
      ifc.zero   = z;
      for (int i = 0; i < wf; i++) cyc(1'b0, 1, cv(0, 2'b00, 0, 1, 0, 0, 0, 0), 1'b0);
      cyc(1'b1, 1, cv(1, 2'b00, 1, 1, 0, 0, 0, 0), 1'b0);
      cyc(1'($urandom_range(0, 1)), 2,
          jmp ? cv(1, 2'b10, 0, 0, 0, 0, 0, 0) : 9'd0, 1'b0);
      m_ret = m_ret + 16'd1;
      if (!(hlt || jmp || ill)) begin
         cyc(1'($urandom_range(0, 1)), 3,
             cv(beq & z, (beq & z) ? 2'b01 : 2'b00, 0, 0, 0, op inside {4'h1, 4'h2, 4'h3}, 0, 0), 1'b0);
         if (ld || sto) begin
            for (int i = 0; i < wm; i++) cyc(1'b0, 4, cv(0, 2'b00, 0, ld, sto, 0, 0, 0), 1'b0);
            cyc(1'b1, 4, cv(0, 2'b00, 0, ld, sto, 0, 0, 0), 1'b0);
         end
         if (!(sto || beq)) cyc(1'($urandom_range(0, 1)), 5, cv(0, 2'b00, 0, 0, 0, 0, 1, ld), 1'b0);
      end
      @(posedge clk);
      #1;
      chk("retired", 32'(ifc.retired), 32'(m_ret));
      chk("next_state", 32'(ifc.state), hlt ? 6 : 1);
   endtask

   initial begin
      logic [3:0] rop;
      rst = 1'b1;
      ifc.start = 1'b0;
      ifc.opcode = 4'h0;
      ifc.zero = 1'b0;
      ifc.mem_ready = 1'b1;
      m_ret = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(ifc.state), 0);
      chk("rst_ctl", 32'(ctl_now()), 0);
      chk("rst_halted", 32'(ifc.halted), 0);
      chk("rst_retired", 32'(ifc.retired), 0);
      @(negedge clk);
      rst = 1'b0;

      // IDLE holds without start
      cyc(1'b1, 0, 9'd0, 1'b0);
      do_start();
      run_instr(4'h0, 1'b0, 0, 0);        // ALU, retired=1
      run_instr(4'h2, 1'b0, 0, 3);        // LOAD with 3 MEM stalls
      run_instr(4'h4, 1'b1, 0, 0);        // BEQ taken
      run_instr(4'h4, 1'b0, 0, 0);        // BEQ not taken
      run_instr(4'h9, 1'b0, 0, 0);        // illegal as NOP
      run_instr(4'h3, 1'b0, 1, 2);        // STORE with stalls
      run_instr(4'h1, 1'b1, 2, 0);        // ADDI
      run_instr(4'h5, 1'b0, 0, 0);        // JMP

      for (int n = 0; n < 150; n++) begin
         rop = 4'($urandom_range(0, 14));
         run_instr(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // wrap: preload the counter during a fetch stall, then retire twice
      @(negedge clk);
      ifc.mem_ready = 1'b0;
      force ifc.retired = 16'hFFFE;
      #1 release ifc.retired;
      m_ret = 16'hFFFE;
      run_instr(4'h5, 1'b0, 0, 0);
      chk("wrap_ffff", 32'(ifc.retired), 32'h0000FFFF);
      run_instr(4'h9, 1'b0, 0, 0);
      chk("wrap_0000", 32'(ifc.retired), 0);

      // reset in the middle of a LOAD memory stall, with start also high
      ifc.opcode = 4'h2;
      cyc(1'b1, 1, cv(1, 2'b00, 1, 1, 0, 0, 0, 0), 1'b0);
      cyc(1'b1, 2, 9'd0, 1'b0);
      cyc(1'b1, 3, cv(0, 2'b00, 0, 0, 0, 1, 0, 0), 1'b0);
      cyc(1'b0, 4, cv(0, 2'b00, 0, 1, 0, 0, 0, 0), 1'b0);
      @(negedge clk);
      rst = 1'b1;
      ifc.start = 1'b1;
      @(posedge clk);
      #1;
      chk("memrst_state", 32'(ifc.state), 0);
      chk("memrst_ctl", 32'(ctl_now()), 0);
      chk("memrst_retired", 32'(ifc.retired), 0);
      m_ret = '0;
      @(negedge clk);
      rst = 1'b0;
      ifc.start = 1'b0;

      // HALT: start pulses are ignored, then reset clears everything
      do_start();
      run_instr(4'h2, 1'b0, 0, 0);
      run_instr(4'hF, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         ifc.start = 1'(i & 1);
         cyc(1'($urandom_range(0, 1)), 6, 9'd0, 1'b1);
      end
      chk("halt_retired", 32'(ifc.retired), 2);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("halt_rst_state", 32'(ifc.state), 0);
      chk("halt_rst_retired", 32'(ifc.retired), 0);
      chk("halt_rst_halted", 32'(ifc.halted), 0);
      rst = 1'b0;
      ifc.start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
